mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage sequencer between the pipeline and a wait-stated data memory, using a req/ack handshake.
- Decodes the load/store opcode and checks alignment.
- For stores, generates big-endian byte enables and lane-shifted write data.
- For loads, captures the raw read word and presents the latched opcode and address low bits to the load-data shifter. Stalls the pipeline for the duration of the access.

Parameters:
- TIMEOUT_CYC, 255, number of cycles in REQ without dmem_ack before timeout fires (used only with MEM_TIMEOUT_EN).
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_op_valid  input  1  MEM stage holds a load/store this cycle.
- ir_op  input  6  opcode IR[31:26] of the MEM-stage instruction.
- addr  input  ADDR_W  effective byte address.
- store_data  input  32  rt value for stores.
- stall  output  1  freeze upstream pipeline.
- load_valid  output  1  one-cycle pulse; load result fields valid.
- load_raw  output  32  captured dmem_rdata.
- load_addr_lo  output  2  latched addr[1:0], drives the shifter.
- load_ir  output  6  latched ir_op, drives the shifter.
- addr_err  output  1  one-cycle pulse on misaligned or illegal access.
- dmem_req  output  1  memory request.
- dmem_we  output  1  write, qualified by dmem_req.
- dmem_be  output  4  byte enables; bit3 = bits 31:24 = byte address 0.
- dmem_addr  output  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- dmem_wdata  output  32  lane-aligned write data.
- dmem_ack  input  1  memory done; rdata valid in the same cycle for reads.
- dmem_rdata  input  32  read word.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: stall, load_valid, load_raw, load_addr_lo, load_ir, addr_err, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata.
- Decoded ops:
  - Loads: lb 100000, lh 100001, lwl 100010, lw 100011, lbu 100100, lhu 100101, lwr 100110.
  - Stores: sb 101000, sh 101001, swl 101010, sw 101011, swr 101110.
  - Any other opcode with mem_op_valid is ignored: no stall, no error.
- Alignment rules:
  - lh, lhu, sh require addr[0]=0.
  - lw, sw require addr[1:0]=0.
  - Violation in IDLE: addr_err pulses the next cycle, no memory access, no stall.
- IDLE: on a valid, aligned op, register dmem_addr, dmem_we, dmem_be, dmem_wdata, load_ir and load_addr_lo, then go to REQ. stall is asserted combinationally in that same cycle.
- REQ:
  - dmem_req=1 and all dmem_* outputs are held stable until dmem_ack.
  - On ack: for loads, load_raw<=dmem_rdata. Then go to DONE and drop dmem_req, dmem_we and dmem_be to 0.
  - stall=1 throughout REQ.
- DONE:
  - stall=0.
  - load_valid=1 for this single cycle, loads only.
  - Return to IDLE.
  - mem_op_valid is not sampled in DONE; the next op is accepted at the earliest in the following IDLE cycle.
- Minimum latency with ack in the first REQ cycle: accept cycle → REQ → DONE, i.e. 2 stall cycles.
- Store byte enables and data, k=addr[1:0]:
  - sb: be=4'b1000>>k; wdata={4{rt[7:0]}}.
  - sh: be=k[1]?4'b0011:4'b1100; wdata={2{rt[15:0]}}.
  - sw: be=4'b1111; wdata=rt.
  - swl: be=4'b1111>>k; wdata=rt>>(8k).
  - swr: be=(4'b1111<<(3-k)) truncated to 4 bits; wdata=rt<<(8(3-k)).
- Loads: dmem_be=4'b1111 and dmem_we=0.
- dmem_ack outside REQ is ignored.
- mem_op_valid changing while in REQ or DONE is ignored; the op latched at accept is the one executed.
- Reset asserted mid-access returns to IDLE immediately and drops dmem_req. No load_valid is issued for the aborted access.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8+-bit wait counter clears on accept and increments each REQ cycle without ack. When it reaches TIMEOUT_CYC, the access is abandoned:
  - dmem_req drops.
  - addr_err pulses for 1 cycle.
  - FSM goes to DONE with load_valid held 0.
- Undefined: no counter; REQ waits indefinitely for dmem_ack.

Test Plan:
1. lw addr=0x100, ack 3 cycles after req, rdata=0xDEADBEEF:
   - dmem_addr=0x100, be=1111, we=0.
   - stall high for 4 cycles.
   - load_valid pulses with load_raw=0xDEADBEEF, load_addr_lo=0, load_ir=100011.
2. sb addr=0x203, rt=0x000000A5, immediate ack:
   - dmem_addr=0x200, be=0001, wdata=0xA5A5A5A5, we=1.
   - stall high for exactly 2 cycles; no load_valid.
3. swl addr=0x301, rt=0x11223344 → be=0111, wdata=0x00112233.
4. swr addr=0x301, rt=0x11223344 → be=1100, wdata=0x33440000.
5. lh addr=0x401 → addr_err single pulse, dmem_req never asserts, stall stays 0. Then lbu addr=0x401 is accepted normally with load_addr_lo=01.
6. rst_n low during REQ of an lw:
   - dmem_req and stall drop asynchronously, with no load_valid.
   - After release, a new sw to 0x500 completes normally.
   - With MEM_TIMEOUT_EN, no ack → addr_err exactly TIMEOUT_CYC cycles after req rises.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer for a wait-stated data memory.
// Decodes the opcode, checks alignment, builds big-endian byte enables and
// lane-shifted store data, runs a req/ack access and stalls the pipeline
// while it is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYC REQ cycles without dmem_ack (reported through addr_err).
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_op_valid,
    input  logic [5:0]        ir_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_raw,
    output logic [1:0]        load_addr_lo,
    output logic [5:0]        load_ir,
    output logic              addr_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWR = 6'b101110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_is_load;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_accept;
    logic        w_align_err;
    logic        w_ack_done;
    logic        w_timeout;
    logic        w_timeout_hit;
    logic [1:0]  w_k;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_k = addr[1:0];

    // Opcode classification and alignment check
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        case (ir_op)
            OP_LB, OP_LWL, OP_LBU, OP_LWR: w_is_load = 1'b1;
            OP_LH, OP_LHU: begin
                w_is_load  = 1'b1;
                w_misalign = addr[0];
            end
            OP_LW: begin
                w_is_load  = 1'b1;
                w_misalign = |addr[1:0];
            end
            OP_SB, OP_SWL, OP_SWR: w_is_store = 1'b1;
            OP_SH: begin
                w_is_store = 1'b1;
                w_misalign = addr[0];
            end
            OP_SW: begin
                w_is_store = 1'b1;
                w_misalign = |addr[1:0];
            end
            default: ;
        endcase
    end

    // Big-endian byte enables and lane-aligned store data; loads read all lanes
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        case (ir_op)
            OP_SB: begin
                w_be    = 4'b1000 >> w_k;
                w_wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                w_be    = w_k[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{store_data[15:0]}};
            end
            OP_SW: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
            OP_SWL: begin
                w_be    = 4'b1111 >> w_k;
                w_wdata = store_data >> {w_k, 3'b000};
            end
            OP_SWR: begin
                w_be    = 4'b1111 << (2'd3 - w_k);
                w_wdata = store_data << {2'd3 - w_k, 3'b000};
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, combinational stall and per-cycle event strobes
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        w_accept     = 1'b0;
        w_align_err  = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_op_valid && (w_is_load || w_is_store)) begin
                    if (w_misalign) begin
                        w_align_err = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        stall        = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] r_wait_cnt;

    // Count REQ cycles spent waiting for dmem_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_REQ && !dmem_ack) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Fires in the REQ cycle whose increment would reach TIMEOUT_CYC
    assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout;

    assign w_timeout_hit    = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // Memory interface and load result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_be      <= 4'b0000;
            dmem_addr    <= '0;
            dmem_wdata   <= 32'h0;
            load_ir      <= 6'h0;
            load_addr_lo <= 2'b00;
            load_raw     <= 32'h0;
            load_valid   <= 1'b0;
            addr_err     <= 1'b0;
            r_is_load    <= 1'b0;
        end else begin
            load_valid <= w_ack_done & r_is_load;
            addr_err   <= w_align_err | w_timeout;
            if (w_accept) begin
                dmem_req     <= 1'b1;
                dmem_we      <= w_is_store;
                dmem_be      <= w_be;
                dmem_addr    <= {addr[ADDR_W-1:2], 2'b00};
                dmem_wdata   <= w_wdata;
                load_ir      <= ir_op;
                load_addr_lo <= addr[1:0];
                r_is_load    <= w_is_load;
            end else if (w_ack_done || w_timeout) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
                dmem_be  <= 4'b0000;
                if (w_ack_done && r_is_load) begin
                    load_raw <= dmem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table of load/store accesses with a
// scoreboard queue of expected memory-side values, plus hand sequences for
// misalignment, illegal opcodes, reset mid-access and the optional timeout.
module tb_mem_access_ctrl;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned TIMEOUT_CYC = 255;
    localparam int          NVEC        = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_op_valid;
    logic [5:0]        ir_op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_data;
    logic              stall;
    logic              load_valid;
    logic [31:0]       load_raw;
    logic [1:0]        load_addr_lo;
    logic [5:0]        load_ir;
    logic              addr_err;
    logic              dmem_req;
    logic              dmem_we;
    logic [3:0]        dmem_be;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        int          ack_dly;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        int          stall_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] daddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic        lv;
        logic [31:0] raw;
        logic [1:0]  lo;
        logic [5:0]  ir;
        int          stall_cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[NVEC];

    mem_access_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_op_valid (mem_op_valid),
        .ir_op        (ir_op),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_raw     (load_raw),
        .load_addr_lo (load_addr_lo),
        .load_ir      (load_ir),
        .addr_err     (addr_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_be      (dmem_be),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One complete access; expected memory-side values go through the queue
    task automatic run_op(input vec_t v);
        exp_t e;
        exp_t g;
        int   sc;
        @(negedge clk);
        mem_op_valid = 1'b1;
        ir_op        = v.op;
        addr         = v.a;
        store_data   = v.sd;
        e.daddr      = {v.a[31:2], 2'b00};
        e.be         = v.be;
        e.wd         = v.wd;
        e.we         = v.we;
        e.lv         = ~v.we;
        e.raw        = v.rdata;
        e.lo         = v.a[1:0];
        e.ir         = v.op;
        e.stall_cyc  = v.stall_cyc;
        sb_q.push_back(e);
        #1;
        check("accept_stall", 32'(stall), 32'd1);
        sc = stall ? 1 : 0;
        @(negedge clk);
        mem_op_valid = 1'b0;
        ir_op        = 6'h3f;
        addr         = '1;
        store_data   = $urandom;
        check("req_rise", 32'(dmem_req), 32'd1);
        g = sb_q.pop_front();
        check("dmem_addr", dmem_addr, g.daddr);
        check("dmem_be", 32'(dmem_be), 32'(g.be));
        check("dmem_we", 32'(dmem_we), 32'(g.we));
        if (g.we) check("dmem_wdata", dmem_wdata, g.wd);
        for (int c = 0; c <= v.ack_dly; c++) begin
            if (stall) sc++;
            check("req_hold", 32'(dmem_req), 32'd1);
            check("be_hold", 32'(dmem_be), 32'(g.be));
            if (c == v.ack_dly) begin
                dmem_ack   = 1'b1;
                dmem_rdata = v.rdata;
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
        end
        check("done_stall", 32'(stall), 32'd0);
        check("done_req", 32'(dmem_req), 32'd0);
        check("done_be", 32'(dmem_be), 32'd0);
        check("done_we", 32'(dmem_we), 32'd0);
        check("load_valid", 32'(load_valid), 32'(g.lv));
        if (g.lv) begin
            check("load_raw", load_raw, g.raw);
            check("load_addr_lo", 32'(load_addr_lo), 32'(g.lo));
            check("load_ir", 32'(load_ir), 32'(g.ir));
        end
        check("stall_cycles", 32'(sc), 32'(g.stall_cyc));
        @(negedge clk);
        check("lv_single", 32'(load_valid), 32'd0);
    endtask

    // Rejected access: addr_err pulse, no request, no stall
    task automatic bad_op(input logic [5:0] op, input logic [31:0] a, input logic exp_err);
        @(negedge clk);
        mem_op_valid = 1'b1;
        ir_op        = op;
        addr         = a;
        #1;
        check("bad_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_op_valid = 1'b0;
        check("bad_err", 32'(addr_err), 32'(exp_err));
        check("bad_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        check("bad_err_pulse", 32'(addr_err), 32'd0);
        check("bad_req2", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //         op         addr         rt            dly rdata         be       wdata         we  stall
        tbl[0]  = '{6'b100011, 32'h100, 32'h0,        2, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0, 4};
        tbl[1]  = '{6'b101000, 32'h203, 32'h000000A5, 0, 32'h0,        4'b0001, 32'hA5A5A5A5, 1'b1, 2};
        tbl[2]  = '{6'b101010, 32'h301, 32'h11223344, 1, 32'h0,        4'b0111, 32'h00112233, 1'b1, 3};
        tbl[3]  = '{6'b101110, 32'h301, 32'h11223344, 0, 32'h0,        4'b1100, 32'h33440000, 1'b1, 2};
        tbl[4]  = '{6'b101001, 32'h402, 32'h0000BEEF, 0, 32'h0,        4'b0011, 32'hBEEFBEEF, 1'b1, 2};
        tbl[5]  = '{6'b101000, 32'h200, 32'h0000005A, 1, 32'h0,        4'b1000, 32'h5A5A5A5A, 1'b1, 3};
        tbl[6]  = '{6'b101110, 32'h303, 32'hAABBCCDD, 0, 32'h0,        4'b1111, 32'hAABBCCDD, 1'b1, 2};
        tbl[7]  = '{6'b101010, 32'h300, 32'hAABBCCDD, 0, 32'h0,        4'b1111, 32'hAABBCCDD, 1'b1, 2};
        tbl[8]  = '{6'b100000, 32'h007, 32'h0,        0, 32'h12345678, 4'b1111, 32'h0,        1'b0, 2};
        tbl[9]  = '{6'b100110, 32'h106, 32'h0,        3, 32'hCAFE0001, 4'b1111, 32'h0,        1'b0, 5};
        tbl[10] = '{6'b100100, 32'h401, 32'h0,        0, 32'h0BADF00D, 4'b1111, 32'h0,        1'b0, 2};
        tbl[11] = '{6'b101011, 32'h500, 32'hCAFEF00D, 1, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b1, 3};

        rst_n        = 1'b0;
        mem_op_valid = 1'b0;
        ir_op        = 6'h0;
        addr         = '0;
        store_data   = 32'h0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_lv", 32'(load_valid), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_raw", load_raw, 32'd0);
        check("rst_ir", 32'({load_ir, load_addr_lo, dmem_we}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) run_op(tbl[i]);

        // Misaligned and illegal accesses, then the same address as a byte load
        bad_op(6'b100001, 32'h401, 1'b1);
        bad_op(6'b100011, 32'h102, 1'b1);
        bad_op(6'b101001, 32'h003, 1'b1);
        bad_op(6'b101011, 32'h501, 1'b1);
        bad_op(6'b100111, 32'h000, 1'b0);
        bad_op(6'b000000, 32'h000, 1'b0);
        run_op(tbl[10]);

        // Reset in the middle of a load's REQ phase
        @(negedge clk);
        mem_op_valid = 1'b1;
        ir_op        = 6'b100011;
        addr         = 32'h100;
        @(negedge clk);
        mem_op_valid = 1'b0;
        check("mid_req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req", 32'(dmem_req), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_be", 32'(dmem_be), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("abort_lv", 32'(load_valid), 32'd0);
        check("idle_ack_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;
        @(negedge clk);
        check("abort_lv2", 32'(load_valid), 32'd0);
        run_op(tbl[11]);

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            @(negedge clk);
            mem_op_valid = 1'b1;
            ir_op        = 6'b100011;
            addr         = 32'h600;
            @(negedge clk);
            mem_op_valid = 1'b0;
            check("to_req", 32'(dmem_req), 32'd1);
            n = 0;
            while (!addr_err && n < int'(TIMEOUT_CYC) + 20) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", 32'(n), TIMEOUT_CYC);
            check("to_req_drop", 32'(dmem_req), 32'd0);
            check("to_lv", 32'(load_valid), 32'd0);
            check("to_stall", 32'(stall), 32'd0);
            @(negedge clk);
            check("to_err_pulse", 32'(addr_err), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
